// File: rtl/galetron_pkg.sv
// galetron_pkg: shared loader constants and FSM state encoding.
package galetron_pkg;
   localparam int ADDR_WIDTH = 10;
   localparam int DATA_WIDTH = 32;
   localparam int MAX_WORDS = 1024;
   typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, WRITE, FINISH, ERROR} state_t;
endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// byte_assembler: packs a big-endian byte stream into 4-byte words.
module byte_assembler #(
   parameter int DATA_WIDTH = galetron_pkg::DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  shift_en,
   input  logic [7:0]            byte_in,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_complete
);
   logic [1:0] byte_count;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         word       <= '0;
         byte_count <= '0;
      end else if (clear) begin
         word       <= '0;
         byte_count <= '0;
      end else if (shift_en) begin
         word       <= {word[DATA_WIDTH-9:0], byte_in};
         byte_count <= byte_count + 2'd1;
      end
   assign word_complete = shift_en && byte_count == 2'd3;
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: streams a length-prefixed program into instruction RAM.
module instruction_loader #(
   parameter int ADDR_WIDTH = galetron_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = galetron_pkg::DATA_WIDTH,
   parameter int MAX_WORDS  = galetron_pkg::MAX_WORDS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   output logic                  byte_ready,
   output logic [ADDR_WIDTH-1:0] i_ram_writing_address,
   output logic [DATA_WIDTH-1:0] i_ram_input,
   output logic                  flag_write_i_ram,
   output logic                  loading,
   output logic                  done,
   output logic                  error
);
   import galetron_pkg::*;
   state_t state, next_state;
   logic [ADDR_WIDTH-1:0] index;
   logic [15:0] count, hdr;
   logic [DATA_WIDTH-1:0] word;
   logic err, xfer, word_complete, last, bad, accept_start;
   assign xfer         = byte_valid && byte_ready;
   assign accept_start = state == IDLE && start;
   assign hdr          = {count[15:8], byte_in};
   assign bad          = hdr == 16'd0 || int'(hdr) > MAX_WORDS;
   assign last         = int'(index) + 1 == int'(count);
   byte_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
      .clock(clock),
      .reset(reset),
      .clear(accept_start),
      .shift_en(state == DATA && xfer),
      .byte_in(byte_in),
      .word(word),
      .word_complete(word_complete)
   );
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else state <= next_state;
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = start ? HDR_HI : IDLE;
         HDR_HI:  next_state = xfer ? HDR_LO : HDR_HI;
         HDR_LO:  next_state = xfer ? (bad ? ERROR : DATA) : HDR_LO;
         DATA:    next_state = word_complete ? WRITE : DATA;
         WRITE:   next_state = last ? FINISH : DATA;
         default: next_state = IDLE;
      endcase
   end
   // The final write leaves the index in place so the address never wraps.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         index <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (accept_start) begin
         index <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (state == HDR_HI && xfer) begin
         count[15:8] <= byte_in;
      end else if (state == HDR_LO && xfer) begin
         count[7:0] <= byte_in;
         err        <= bad;
      end else if (state == WRITE && !last) begin
         index <= index + 1'b1;
      end
   assign byte_ready            = state == HDR_HI || state == HDR_LO || state == DATA;
   assign flag_write_i_ram      = state == WRITE;
   assign loading               = state != IDLE && state != ERROR;
   assign done                  = state == FINISH;
   assign error                 = err;
   assign i_ram_writing_address = index;
   assign i_ram_input           = word;
endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, the instruction RAM write-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the instruction word width.
REQ-003 The block SHALL have parameter MAX_WORDS, default 1024, the largest accepted program length.
REQ-004 One clock and one reset: clock input 1, rising-edge system clock; reset input 1, asynchronous, active-high.
REQ-005 start input 1: one-cycle pulse that begins a program load.
REQ-006 byte_in input 8: program byte stream.
REQ-007 byte_valid input 1: byte_in holds a valid byte.
REQ-008 byte_ready output 1: loader accepts a byte this cycle.
REQ-009 i_ram_writing_address output ADDR_WIDTH: instruction RAM write address.
REQ-010 i_ram_input output DATA_WIDTH: instruction RAM write data.
REQ-011 flag_write_i_ram output 1: instruction RAM write enable.
REQ-012 loading output 1: a load is in progress; used to stall the CPU.
REQ-013 done output 1: one-cycle pulse at successful load end.
REQ-014 error output 1: sticky bad-header indication.

Function
REQ-015 A byte SHALL transfer only on a rising edge with byte_valid=1 and byte_ready=1.
REQ-016 FSM states SHALL be IDLE, HDR_HI, HDR_LO, DATA, WRITE, FINISH, ERROR.
REQ-017 IDLE + start=1 SHALL go to HDR_HI, clear error, and zero word_count and the address.
REQ-018 byte_ready SHALL be 1 only in HDR_HI, HDR_LO and DATA.
REQ-019 Header: HDR_HI takes count[15:8], then HDR_LO takes count[7:0] (big-endian, 16 bits).
REQ-020 After HDR_LO, count=0 or count>MAX_WORDS SHALL go to ERROR; otherwise go to DATA.
REQ-021 DATA SHALL assemble 4 bytes per word, first byte into bits [31:24] and last into [7:0]; the 4th accepted byte moves to WRITE.
REQ-022 WRITE SHALL last exactly one cycle with flag_write_i_ram=1, i_ram_input=assembled word, i_ram_writing_address=current index.
REQ-023 After WRITE, the index SHALL increment; if index+1=count go to FINISH, else return to DATA.
REQ-024 FINISH SHALL last one cycle with done=1, then go to IDLE.
REQ-025 ERROR SHALL hold error=1 and return to IDLE in the next cycle; error stays 1 until the next accepted start.
REQ-026 loading SHALL be 1 in every state except IDLE and ERROR.
REQ-027 start SHALL be ignored outside IDLE.
REQ-028 Gaps in byte_valid SHALL stall without losing the partial word or the byte position.
REQ-029 Address SHALL NOT wrap: the last write of a MAX_WORDS program is at address 1023.
REQ-030 flag_write_i_ram SHALL be 0 in all states other than WRITE, and the loader SHALL NOT issue a write without a complete 4-byte word.

Reset
REQ-031 Reset SHALL force IDLE and set byte_ready, flag_write_i_ram, loading, done and error to 0, i_ram_writing_address to 0, and i_ram_input to 0, asynchronously.
REQ-032 Reset mid-load SHALL abandon the load with no further RAM writes; words already written stay in RAM.

Structure
REQ-033 A shared package galetron_pkg SHALL hold the FSM state enum and the constants ADDR_WIDTH, DATA_WIDTH and MAX_WORDS.
REQ-034 One sub-module, byte_assembler, SHALL hold the 4-byte shift register and the 2-bit byte counter, with clear, shift-enable and word_complete signals.

Verification
REQ-035 Load of 2 words: start, bytes 00 02 6C 00 00 00 74 40 00 00 -> writes 0x6C000000@0 then 0x74400000@1, each a single-cycle flag pulse; done one cycle after the 2nd write; loading falls with done.
REQ-036 Bad header: header 00 00 -> error=1, no RAM write; header 04 01 (1025) -> error=1; a later start clears error.
REQ-037 Gaps: byte_valid toggles 1/0 every cycle during a 1-word load of 0x0444000C -> the word is correct at address 0, with exactly one write.
REQ-038 Mid-load reset: reset after 6 of 8 data bytes -> 0x6C000000@0 written, no write to address 1, all outputs at 0, state IDLE.
REQ-039 Busy start: start pulses during DATA are ignored -> the sequence completes unchanged.
REQ-040 Max length: header 04 00 with 1024 incrementing words -> the last write is at address 1023, done=1, error=0.
